// File: rtl/encrypt_pkg.sv
// encrypt_pkg: ASCII bounds, key selector and stage-1 record shared by the encrypt and decrypt pipes.
package encrypt_pkg;
    localparam logic [7:0] UPPER_LO  = 8'h41;
    localparam logic [7:0] UPPER_HI  = 8'h5A;
    localparam logic [7:0] LOWER_LO  = 8'h61;
    localparam logic [7:0] LOWER_HI  = 8'h7A;
    localparam int         ALPHA_LEN = 26;
    localparam int         AMT_W     = 4;

    typedef enum logic [1:0] {KEY1, KEY2, KEY3} key_sel_t;

    typedef struct packed {
        logic             valid;
        logic [7:0]       data;
        logic             is_upper;
        logic             is_lower;
        logic             shift_en;
        logic [AMT_W-1:0] shift_amt;
        logic             mode;
        logic [7:0]       key;
    } enc_stage_t;
endpackage

// File: rtl/alpha_shift.sv
// alpha_shift: combinational modular shift of one letter within its own case; other bytes pass through.
module alpha_shift
    import encrypt_pkg::*;
(
    input  logic [7:0]       din,
    input  logic             is_upper,
    input  logic             is_lower,
    input  logic [AMT_W-1:0] amt,
    output logic [7:0]       dout
);
    logic [7:0] base;
    logic [7:0] diff;
    logic [5:0] sum;
    logic [5:0] wrapped;

    // Largest sum is 25 + 15, so a single subtract of 26 always lands back in range.
    always_comb begin
        base    = is_upper ? UPPER_LO : LOWER_LO;
        diff    = din - base;
        sum     = {1'b0, diff[4:0]} + 6'(amt);
        wrapped = (sum >= 6'(ALPHA_LEN)) ? sum - 6'(ALPHA_LEN) : sum;
        dout    = (is_upper || is_lower) ? base + {2'b00, wrapped} : din;
    end
endmodule

// File: rtl/encrypt_pipe.sv
// encrypt_pipe: capture -> alphabetic shift -> key XOR, one byte per cycle, rotating k1->k2->k3.
module encrypt_pipe
    import encrypt_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int SHIFT_W = AMT_W,
    parameter int ROT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [7:0]         din,
    input  logic [7:0]         k1,
    input  logic [7:0]         k2,
    input  logic [7:0]         k3,
    input  logic [ROT_W-1:0]   rot_freq,
    input  logic               shift_en,
    input  logic [SHIFT_W-1:0] shift_amt,
    input  logic               mode,
    output logic               v,
    output logic [7:0]         dout
);
    if (LATENCY != 3 || SHIFT_W != AMT_W) begin : g_bad_param
        $error("encrypt_pipe: LATENCY must be 3 and SHIFT_W must equal AMT_W");
    end

    key_sel_t         key_sel, key_nxt;
    logic [ROT_W-1:0] cnt, cnt_nxt;
    logic             rotate;
    logic [7:0]       key_cur;
    enc_stage_t       s1;
    logic [7:0]       shifted;
    logic             s2_v, s2_mode;
    logic [7:0]       s2_data, s2_key;

    // The accepted byte always snapshots the pre-rotation key.
    always_comb begin
        key_cur = (key_sel == KEY2) ? k2 : (key_sel == KEY3) ? k3 : k1;
        rotate  = en && (rot_freq != '0) && (cnt >= rot_freq - ROT_W'(1));
        cnt_nxt = !en ? cnt : (rot_freq == '0 || rotate) ? '0 : cnt + ROT_W'(1);
        key_nxt = !rotate ? key_sel : (key_sel == KEY1) ? KEY2 : (key_sel == KEY2) ? KEY3 : KEY1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_sel <= KEY1;
            cnt     <= '0;
        end else begin
            key_sel <= key_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
        end else begin
            s1.valid <= en;
            if (en) begin
                s1.data      <= din;
                s1.is_upper  <= (din >= UPPER_LO) && (din <= UPPER_HI);
                s1.is_lower  <= (din >= LOWER_LO) && (din <= LOWER_HI);
                s1.shift_en  <= shift_en;
                s1.shift_amt <= shift_amt;
                s1.mode      <= mode;
                s1.key       <= key_cur;
            end
        end
    end

    alpha_shift u_shift (
        .din      (s1.data),
        .is_upper (s1.is_upper && s1.shift_en),
        .is_lower (s1.is_lower && s1.shift_en),
        .amt      (s1.shift_amt),
        .dout     (shifted)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v    <= 1'b0;
            s2_mode <= 1'b0;
            s2_data <= '0;
            s2_key  <= '0;
            v       <= 1'b0;
            dout    <= '0;
        end else begin
            s2_v <= s1.valid;
            v    <= s2_v;
            if (s1.valid) begin
                s2_mode <= s1.mode;
                s2_data <= shifted;
                s2_key  <= s1.key;
            end
            if (s2_v) dout <= s2_mode ? s2_data ^ s2_key : s2_data;
        end
    end
endmodule

// File: tb/tb_encrypt_pipe.sv
// tb_encrypt_pipe: directed test-plan steps plus a randomized stream against a queue-based reference model.
module tb_encrypt_pipe;
    logic       clk = 0, rst = 0, en = 0, shift_en = 0, mode = 0;
    logic [7:0] din = 0, k1 = 0, k2 = 0, k3 = 0;
    logic [2:0] rot_freq = 0;
    logic [3:0] shift_amt = 0;
    logic       v;
    logic [7:0] dout;

    int checks = 0, errors = 0;

    typedef struct {bit v; logic [7:0] d;} ent_t;
    ent_t       pipe[$];
    logic [7:0] want_dout;
    bit         want_v;
    int         m_key, m_cnt;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    encrypt_pipe dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .k1(k1), .k2(k2), .k3(k3),
        .rot_freq(rot_freq), .shift_en(shift_en), .shift_amt(shift_amt), .mode(mode),
        .v(v), .dout(dout)
    );

    task automatic chk(string tag, logic [8:0] obs, logic [8:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] caesar(logic [7:0] c, bit se, int amt);
        int b;
        if (!se) return c;
        if (c >= 8'h41 && c <= 8'h5A) b = 65;
        else if (c >= 8'h61 && c <= 8'h7A) b = 97;
        else return c;
        return 8'((int'(c) - b + amt) % 26 + b);
    endfunction

    task automatic model_reset();
        ent_t e;
        e.v = 0;
        e.d = 0;
        pipe = {};
        pipe.push_back(e);
        pipe.push_back(e);
        want_dout = 0;
        want_v = 0;
        m_key = 0;
        m_cnt = 0;
    endtask

    // Called right after each rising edge: accepts the byte seen at that edge and retires the one from two edges ago.
    task automatic model_edge();
        ent_t       e, o;
        logic [7:0] key;
        e.v = en;
        e.d = 0;
        if (en) begin
            key = (m_key == 0) ? k1 : (m_key == 1) ? k2 : k3;
            e.d = caesar(din, shift_en, int'(shift_amt)) ^ (mode ? key : 8'h00);
            if (rot_freq == 0) m_cnt = 0;
            else if (m_cnt >= int'(rot_freq) - 1) begin
                m_cnt = 0;
                m_key = (m_key + 1) % 3;
            end else m_cnt++;
        end
        pipe.push_back(e);
        o = pipe.pop_front();
        want_v = o.v;
        if (o.v) want_dout = o.d;
    endtask

    task automatic step(bit e, logic [7:0] d);
        en = e;
        din = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("v", {8'h00, v}, {8'h00, want_v});
        chk("dout", {1'b0, dout}, {1'b0, want_dout});
        if (v) got.push_back(dout);
    endtask

    task automatic do_reset();
        en = 0;
        rst = 0;
        #1;
        model_reset();
        chk("rst_v", {8'h00, v}, 9'h000);
        chk("rst_dout", {1'b0, dout}, 9'h000);
        @(posedge clk);
        #1;
        rst = 1;
        got = {};
    endtask

    task automatic cfg(bit m, bit se, logic [3:0] a, logic [2:0] rf, logic [7:0] a1, logic [7:0] a2, logic [7:0] a3);
        mode = m;
        shift_en = se;
        shift_amt = a;
        rot_freq = rf;
        k1 = a1;
        k2 = a2;
        k3 = a3;
    endtask

    initial begin
        bit en_pat[6] = '{1, 0, 1, 1, 0, 1};
        logic [7:0] plan[4];
        do_reset();

        // Capture edge plus two more edges: output valid right after the third edge.
        cfg(1, 1, 1, 0, 8'h11, 8'h22, 8'h33);
        step(1, 8'h42);
        step(0, 0);
        step(0, 0);
        chk("p1_out", {v, dout}, {1'b1, 8'h52});
        step(0, 0);
        chk("p1_bubble", {v, dout}, {1'b0, 8'h52});

        cfg(0, 1, 1, 0, 8'h11, 8'h22, 8'h33);
        step(1, 8'h5A);
        shift_amt = 15;
        step(1, 8'h7A);
        step(0, 0);
        chk("p2_Z", {v, dout}, {1'b1, 8'h41});
        step(0, 0);
        chk("p2_z", {v, dout}, {1'b1, 8'h6F});

        do_reset();
        cfg(1, 0, 0, 1, 8'h11, 8'hFF, 8'hDE);
        for (int i = 0; i < 7; i++) step(i < 4, 8'h30);
        plan = '{8'h21, 8'hCF, 8'hEE, 8'h21};
        chk("p3_count", 9'(got.size()), 9'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("p3_byte", {1'b0, got[i]}, {1'b0, plan[i]});

        do_reset();
        cfg(1, 0, 0, 2, 8'h11, 8'hFF, 8'hDE);
        for (int i = 0; i < 9; i++) step(i < 6 ? en_pat[i] : 1'b0, 8'h00);
        plan = '{8'h11, 8'h11, 8'hFF, 8'hFF};
        chk("p4_count", 9'(got.size()), 9'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("p4_byte", {1'b0, got[i]}, {1'b0, plan[i]});

        do_reset();
        cfg(1, 0, 0, 1, 8'h11, 8'hFF, 8'hDE);
        step(1, 8'h61);
        step(1, 8'h62);
        #3;
        rst = 0;
        #1;
        model_reset();
        chk("p5_async_v", {8'h00, v}, 9'h000);
        chk("p5_async_dout", {1'b0, dout}, 9'h000);
        @(posedge clk);
        #1;
        rst = 1;
        got = {};
        rot_freq = 0;
        step(1, 8'h00);
        step(0, 0);
        step(0, 0);
        chk("p5_k1", {v, dout}, {1'b1, 8'h11});

        cfg(0, 1, 15, 0, 8'h11, 8'hFF, 8'hDE);
        got = {};
        plan = '{8'h40, 8'h5B, 8'h60, 8'h7B};
        for (int i = 0; i < 6; i++) step(i < 4, i < 4 ? plan[i] : 8'h00);
        chk("p6_count", 9'(got.size()), 9'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("p6_byte", {1'b0, got[i]}, {1'b0, plan[i]});

        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 17 == 0)
                cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom));
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) ? 8'($urandom_range(8'h40, 8'h7B)) : 8'($urandom));
        end
        for (int i = 0; i < 3; i++) step(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
